ibus_resp_model: RTL and testbench
==================================

// Module: ibus_resp_model
// PURPOSE
// - Parametrised instruction-bus slave model for the borb formal/sim harnesses; next generation of the
//   free-running random ibus response regs. Sits between CPU io_iBus_cmd_* and io_iBus_rsp_*.
// - Queues up to DEPTH outstanding fetches, returns them in order with bounded, stall-controlled
//   latency. Payload comes from a solver-driven input; the response stream stays protocol-legal.
// - Flags CPU-side cmd protocol violations for use as formal assertions.
// PARAMETERS
// - ADDR_W    64  cmd/rsp address width
// - DATA_W    64  rsp data width (2 insns per beat)
// - ID_W      16  transaction id width
// - DEPTH      4  max outstanding commands (>=1, power of 2)
// - MIN_LAT    1  min cycles from cmd accept to rsp_valid (>=1)
// - MAX_STALL  3  max consecutive stalled cycles an eligible head may be held (>=0)
// PORTS
// - clock        in   1        clock
// - reset        in   1        sync reset, active-high
// - cmd_valid    in   1        CPU fetch request
// - cmd_ready    out  1        model can accept
// - cmd_address  in   ADDR_W   fetch address
// - cmd_id       in   ID_W     fetch id
// - stall_i      in   1        per-cycle hold request (formal: rand reg)
// - rand_data    in   DATA_W   payload source (formal: rand reg)
// - rsp_valid    out  1        one-cycle response pulse (no ready: CPU always sinks)
// - rsp_data     out  DATA_W   response payload
// - rsp_address  out  ADDR_W   echoed address of the head entry
// - rsp_id       out  ID_W     echoed id of the head entry
// - outstanding  out  clog2(DEPTH)+1  queued, not-yet-responded count
// - proto_err    out  1        sticky cmd protocol violation
// BEHAVIOUR
// - Reset: one clock, sync, active-high. All outputs 0 except cmd_ready=1. Queue, age, stall counters cleared.
//   Reset mid-operation drops every outstanding entry; no rsp_valid in the cycle after reset.
// - Queue: circular FIFO of {address,id,age}. ptr wrap mod DEPTH. cmd_ready = (outstanding<DEPTH),
//   registered-state only, never depends on cmd_valid. Accept = cmd_valid & cmd_ready.
// - Age: 0 on accept, +1 per cycle, saturates at MIN_LAT. Head eligible when age>=MIN_LAT.
// - Issue: eligible head issues when !stall_i OR stall_cnt==MAX_STALL. Outputs registered: issue decided
//   in cycle T -> rsp_valid=1 in T+1 with head addr/id; earliest rsp_valid = accept cycle + MIN_LAT.
// - stall_cnt: +1 each cycle head eligible & not issued; cleared on issue. Max one rsp per cycle, strict order.
// - rsp_data/address/id hold last values when rsp_valid=0.
// - Simultaneous accept+issue: outstanding unchanged. Full: no accept (no same-cycle bypass), issue still proceeds.
// - Empty: no issue, stall_cnt held at 0.
// - proto_err: set when prior cycle had cmd_valid & !cmd_ready and this cycle cmd_valid drops or
//   cmd_address/cmd_id change; sticky until reset.
// CONFIGURATION
// - IBUS_MODEL_PATTERN_EN defined: rsp_data = {~addr[31:0], addr[31:0]} of the issued entry;
//   rand_data ignored. Used for sim benches and deterministic fetch checks.
// - Undefined: rsp_data = rand_data sampled in the issue cycle (formal default).
// TESTING
// - MIN_LAT=2, stall_i=0: cmd accepted cycle T, addr 0x80000000 id 3 -> rsp_valid cycle T+2,
//   rsp_address 0x80000000, rsp_id 3; outstanding 1 then 0.
// - DEPTH=4, stall_i=1, MAX_STALL large: 4 accepts ids 0..3 -> outstanding=4, cmd_ready=0; drop stall
//   -> 4 back-to-back rsp_valid, ids 0,1,2,3.
// - MAX_STALL=3, stall_i held 1: one cmd -> rsp_valid exactly 3 cycles after head becomes eligible.
// - outstanding=2, accept and issue same cycle -> outstanding stays 2; order preserved.
// - cmd_valid=1 while full, cmd_address changed next cycle -> proto_err=1, stays 1 until reset.
// - 3 outstanding, reset pulsed -> next cycle outstanding=0, cmd_ready=1, rsp_valid=0;
//   with IBUS_MODEL_PATTERN_EN, addr 0x00001000 -> rsp_data 0xFFFFEFFF_00001000.

Source files
------------

// File: rtl/ibus_resp_model_if.sv
// ibus_resp_model_if: CPU instruction-bus command/response bundle.
//   master : CPU side. Drives cmd_valid/cmd_address/cmd_id and sinks every response.
//   slave  : memory model side. Drives cmd_ready and the rsp_* signals.
// The response channel has no ready signal, because the CPU always accepts a response.
interface ibus_resp_model_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_address;
  logic [ID_W-1:0]   cmd_id;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_address;
  logic [ID_W-1:0]   rsp_id;

  modport master (
    output cmd_valid, cmd_address, cmd_id,
    input  cmd_ready, rsp_valid, rsp_data, rsp_address, rsp_id
  );

  modport slave (
    input  cmd_valid, cmd_address, cmd_id,
    output cmd_ready, rsp_valid, rsp_data, rsp_address, rsp_id
  );
endinterface

// File: rtl/ibus_resp_model.sv
// ibus_resp_model: instruction-bus slave model for the formal and simulation harnesses.
// It queues up to DEPTH outstanding fetches and answers them in order. Each answer has a
// minimum latency and a bounded number of stall cycles. The model also flags any CPU-side
// command protocol violation.
// Ports:
//   i_clock, i_reset : clock; synchronous active-high reset
//   io_bus           : ibus_resp_model_if.slave (cmd_* in, cmd_ready and rsp_* out)
//   i_stall          : per-cycle request to hold back an eligible head
//   i_rand_data      : payload source (used when pattern mode is off)
//   o_outstanding    : number of accepted commands that have not yet been issued
//   o_proto_err      : sticky flag for a CPU command protocol violation
// Build option: define IBUS_MODEL_PATTERN_EN to make rsp_data = {~addr[31:0], addr[31:0]}
// instead of i_rand_data sampled in the issue cycle.
module ibus_resp_model #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ID_W      = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MIN_LAT   = 1,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  ibus_resp_model_if.slave       io_bus,
  input  logic                   i_stall,
  input  logic [DATA_W-1:0]      i_rand_data,
  output logic [$clog2(DEPTH):0] o_outstanding,
  output logic                   o_proto_err
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(MIN_LAT + 1);
  localparam int unsigned SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [AW-1:0] AgeMax   = AW'(MIN_LAT);
  localparam logic [SW-1:0] StallMax = SW'(MAX_STALL);
  localparam logic [CW-1:0] Full     = CW'(DEPTH);
  localparam logic [PW-1:0] LastSlot = PW'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [ID_W-1:0]   r_id   [DEPTH];
  logic [AW-1:0]     r_age  [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_stall_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_blk;
  logic [ADDR_W-1:0] r_blk_addr;
  logic [ID_W-1:0]   r_blk_id;
  logic              r_proto_err;

  logic              w_ready, w_accept, w_eligible, w_issue, w_violation;
  logic [CW-1:0]     w_count_d;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_rsp_data_d;

  // cmd_ready comes only from registered state. A full queue refuses commands even in a
  // cycle where it issues.
  assign w_ready     = (r_count != Full);
  assign w_accept    = io_bus.cmd_valid & w_ready;
  assign w_head_addr = r_addr[r_rptr];

  // An entry enters with age 1, which counts its accept cycle. The head issues when its age
  // is MIN_LAT-1, so the registered response appears when the age reaches MIN_LAT.
  // The earliest issue is the first cycle the entry is in the queue.
  assign w_eligible = (r_count != '0) && ((32'(r_age[r_rptr]) + 32'd1) >= MIN_LAT);
  assign w_issue    = w_eligible & (~i_stall | (r_stall_cnt == StallMax));

  // If the previous cycle had a blocked command, that command must stay valid and unchanged.
  assign w_violation = r_blk & (~io_bus.cmd_valid | (io_bus.cmd_address != r_blk_addr) |
                                (io_bus.cmd_id != r_blk_id));

`ifdef IBUS_MODEL_PATTERN_EN
  logic w_unused_rand;
  assign w_unused_rand = ^i_rand_data;
  assign w_rsp_data_d  = DATA_W'({~w_head_addr[31:0], w_head_addr[31:0]});
`else
  assign w_rsp_data_d  = i_rand_data;
`endif

  always_comb begin
    w_count_d = r_count;
    if (w_accept && !w_issue) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_accept && w_issue) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_addr[r_wptr] <= io_bus.cmd_address;
      r_id[r_wptr]   <= io_bus.cmd_id;
    end
  end

  // Every slot ages, including empty ones. This is harmless because an accept reloads the
  // slot's age.
  always_ff @(posedge i_clock) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_reset) begin
        r_age[i] <= '0;
      end else if (w_accept && (r_wptr == PW'(i))) begin
        r_age[i] <= AW'(1);
      end else if (r_age[i] != AgeMax) begin
        r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_id    <= '0;
      r_blk       <= 1'b0;
      r_blk_addr  <= '0;
      r_blk_id    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= (r_wptr == LastSlot) ? '0 : r_wptr + 1'b1;
      end
      if (w_issue) begin
        r_rptr <= (r_rptr == LastSlot) ? '0 : r_rptr + 1'b1;
      end
      r_count <= w_count_d;

      if (w_issue) begin
        r_stall_cnt <= '0;
      end else if (w_eligible) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      r_rsp_valid <= w_issue;
      if (w_issue) begin
        r_rsp_data <= w_rsp_data_d;
        r_rsp_addr <= w_head_addr;
        r_rsp_id   <= r_id[r_rptr];
      end

      r_blk      <= io_bus.cmd_valid & ~w_ready;
      r_blk_addr <= io_bus.cmd_address;
      r_blk_id   <= io_bus.cmd_id;
      if (w_violation) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign io_bus.cmd_ready   = w_ready;
  assign io_bus.rsp_valid   = r_rsp_valid;
  assign io_bus.rsp_data    = r_rsp_data;
  assign io_bus.rsp_address = r_rsp_addr;
  assign io_bus.rsp_id      = r_rsp_id;
  assign o_outstanding      = r_count;
  assign o_proto_err        = r_proto_err;
endmodule

// File: tb/tb_ibus_resp_model.sv
// Bench for ibus_resp_model with MIN_LAT=2 and MAX_STALL=3.
// A reference process models the bus as a queue of pending fetches, each tagged with its
// accept cycle. On every issue it pushes the expected response into a scoreboard queue.
// A monitor on the falling edge pops that queue and compares whenever a response is due.
// The bench also runs the directed scenarios and then a randomized phase.
module tb_ibus_resp_model;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ID_W      = 16;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MIN_LAT   = 2;
  localparam int unsigned MAX_STALL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [63:0] rand_data;
  logic [2:0]  outstanding;
  logic        proto_err;

  always #5 clk = ~clk;

  ibus_resp_model_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  ibus_resp_model #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .MAX_STALL(MAX_STALL)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .io_bus        (bus),
    .i_stall       (stall),
    .i_rand_data   (rand_data),
    .o_outstanding (outstanding),
    .o_proto_err   (proto_err)
  );

  typedef struct { logic [63:0] addr; logic [15:0] id; int acc; } ent_t;
  typedef struct { logic [63:0] addr; logic [15:0] id; logic [63:0] data; } rsp_t;

  ent_t        mq[$];
  rsp_t        exp_q[$];
  rsp_t        last_rsp;
  int          cyc = 0;
  int          streak = 0;
  bit          m_perr = 1'b0;
  bit          m_blk = 1'b0;
  logic [63:0] m_blk_addr;
  logic [15:0] m_blk_id;
  bit          checking = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It advances one cycle per rising edge and uses the inputs driven
  // during the cycle that is ending.
  always @(posedge clk) begin
    int   c;
    bit   ready;
    ent_t e;
    rsp_t r;
    c   = cyc;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      streak   = 0;
      m_perr   = 1'b0;
      m_blk    = 1'b0;
      last_rsp = '{addr: 64'd0, id: 16'd0, data: 64'd0};
    end else begin
      ready = (mq.size() < int'(DEPTH));
      if (m_blk && (!bus.cmd_valid || bus.cmd_address != m_blk_addr || bus.cmd_id != m_blk_id))
        m_perr = 1'b1;
      m_blk      = bus.cmd_valid && !ready;
      m_blk_addr = bus.cmd_address;
      m_blk_id   = bus.cmd_id;
      // The head can issue in cycle c if its response, visible in cycle c+1, lands at
      // least MIN_LAT cycles after its accept cycle.
      if (mq.size() > 0 && (c + 1 - mq[0].acc) >= int'(MIN_LAT)) begin
        if (!stall || streak == int'(MAX_STALL)) begin
          r.addr = mq[0].addr;
          r.id   = mq[0].id;
`ifdef IBUS_MODEL_PATTERN_EN
          r.data = {~mq[0].addr[31:0], mq[0].addr[31:0]};
`else
          r.data = rand_data;
`endif
          exp_q.push_back(r);
          void'(mq.pop_front());
          streak = 0;
        end else begin
          streak++;
        end
      end
      if (bus.cmd_valid && ready) begin
        e.addr = bus.cmd_address;
        e.id   = bus.cmd_id;
        e.acc  = c;
        mq.push_back(e);
      end
    end
  end

  // Monitor: checks every output once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      if (exp_q.size() > 0) begin
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        last_rsp = exp_q.pop_front();
      end else begin
        chk("rsp_valid idle", 64'(bus.rsp_valid), 64'd0);
      end
      chk("rsp_address", bus.rsp_address, last_rsp.addr);
      chk("rsp_id", 64'(bus.rsp_id), 64'(last_rsp.id));
      chk("rsp_data", bus.rsp_data, last_rsp.data);
      chk("outstanding", 64'(outstanding), 64'(mq.size()));
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(mq.size() < int'(DEPTH)));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
    end
  end

  task automatic drive(input bit v, input logic [63:0] a, input logic [15:0] id, input bit s);
    bus.cmd_valid   = v;
    bus.cmd_address = a;
    bus.cmd_id      = id;
    stall           = s;
    rand_data       = {$urandom, $urandom};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 64'd0, 16'd0, 1'b0);
      next_cycle();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    drive(1'b0, 64'd0, 16'd0, 1'b0);
    next_cycle();
    rst      = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("reset outstanding", 64'(outstanding), 64'd0);
    chk("reset cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // Basic latency: accept in cycle T, response in cycle T+2.
    drive(1'b1, 64'h8000_0000, 16'd3, 1'b0);
    next_cycle();
    drive(1'b0, 64'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("lat outstanding T+1", 64'(outstanding), 64'd1);
    chk("lat rsp_valid T+1", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("lat rsp_valid T+2", 64'(bus.rsp_valid), 64'd1);
    chk("lat rsp_address", bus.rsp_address, 64'h8000_0000);
    chk("lat rsp_id", 64'(bus.rsp_id), 64'd3);
    chk("lat outstanding T+2", 64'(outstanding), 64'd0);
    idle(2);

    // Fill under stall, then release for back-to-back responses.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(i * 8), 16'(i), 1'b1);
      next_cycle();
    end
    drive(1'b0, 64'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("full outstanding", 64'(outstanding), 64'd4);
    chk("full cmd_ready", 64'(bus.cmd_ready), 64'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    chk("b2b pulses", 64'(pulses), 64'd4);
    idle(2);

    // Stall held high: the response is forced after MAX_STALL held cycles.
    drive(1'b1, 64'h2000, 16'd7, 1'b1);
    next_cycle();
    drive(1'b0, 64'd0, 16'd0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("maxstall rsp_valid", 64'(bus.rsp_valid), 64'(k == 5));
      next_cycle();
    end
    idle(2);

    // Accept and issue in the same cycle with two outstanding.
    drive(1'b1, 64'h3000, 16'd10, 1'b1);
    next_cycle();
    drive(1'b1, 64'h3008, 16'd11, 1'b1);
    next_cycle();
    drive(1'b1, 64'h3010, 16'd12, 1'b0);
    @(negedge clk);
    chk("simul pre outstanding", 64'(outstanding), 64'd2);
    next_cycle();
    drive(1'b0, 64'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("simul outstanding", 64'(outstanding), 64'd2);
    chk("simul rsp_id", 64'(bus.rsp_id), 64'd10);
    idle(6);

    // Protocol violation: blocked while full, then address changes.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h4000 + 64'(i * 8), 16'(20 + i), 1'b1);
      next_cycle();
    end
    drive(1'b1, 64'hdead, 16'd99, 1'b1);
    next_cycle();
    drive(1'b1, 64'hbeef, 16'd99, 1'b1);
    @(negedge clk);
    chk("perr before", 64'(proto_err), 64'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'd0, 16'd0, 1'b0);
      @(negedge clk);
      chk("perr sticky", 64'(proto_err), 64'd1);
      next_cycle();
    end
    idle(8);

    // Reset with three outstanding.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h5000 + 64'(i * 8), 16'(30 + i), 1'b1);
      next_cycle();
    end
    drive(1'b0, 64'd0, 16'd0, 1'b1);
    @(negedge clk);
    chk("prereset outstanding", 64'(outstanding), 64'd3);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 64'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("midreset outstanding", 64'(outstanding), 64'd0);
    chk("midreset cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("midreset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midreset proto_err", 64'(proto_err), 64'd0);
    idle(2);

`ifdef IBUS_MODEL_PATTERN_EN
    drive(1'b1, 64'h0000_1000, 16'd5, 1'b0);
    next_cycle();
    drive(1'b0, 64'd0, 16'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("pattern rsp_data", bus.rsp_data, 64'hFFFF_EFFF_0000_1000);
    idle(2);
`endif

    // Randomized traffic. A blocked command is held unchanged, and resets occur occasionally.
    for (int i = 0; i < 3000; i++) begin
      if (m_blk) begin
        stall     = ($urandom_range(0, 9) < 6);
        rand_data = {$urandom, $urandom};
      end else begin
        drive(($urandom_range(0, 9) < 7), {$urandom, $urandom}, 16'($urandom),
              ($urandom_range(0, 9) < 6));
      end
      rst = ($urandom_range(0, 299) == 0);
      next_cycle();
    end
    rst = 1'b0;
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
